// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_pkg;

    // Arbiter operating mode.
    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StLoad  = 2'd2
    } state_e;

    // Which port owns the response in flight.
    typedef enum logic [1:0] {
        OwnNone   = 2'd0,
        OwnFetch  = 2'd1,
        OwnLoader = 2'd2
    } owner_e;

    localparam int unsigned WORD_BYTES = 4;
    // Canonical RV32 nop (addi x0, x0, 0), reserved for fetch-side use.
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

endpackage

// File: rtl/imem_grant.sv
// Fetch-priority grant with a starvation guard for the loader port.
module imem_grant
    import imem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic load,
    input  logic f_req_valid,
    input  logic l_req_valid,
    output logic f_ready,
    output logic l_ready
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            starved;

    assign starved = (cnt_q >= CntW'(STARVE_LIMIT));

    // Ready generation; both readies are forced low while reset is asserted.
    always_comb begin
        f_ready = 1'b0;
        l_ready = 1'b0;
        if (rst_n) begin
            if (run) begin
                // When starved the loader wins this cycle; otherwise fetch has priority.
                f_ready = !(starved && l_req_valid);
                l_ready = starved || !f_req_valid;
            end else if (load) begin
                l_ready = 1'b1;
            end
        end
    end

    // Count consecutive denied loader cycles, saturating at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (!l_req_valid || l_ready) begin
            cnt_d = '0;
        end else if (!starved) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port instruction RAM between the fetch port and the
// loader/debug port. Optional misaligned-fetch error reporting is enabled by
// defining IMEM_ALIGN_CHECK_EN, which adds the f_rsp_err output.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned IDX_W        = $clog2(DEPTH),
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_req_valid,
    output logic             f_req_ready,
    input  logic [31:0]      f_addr,
    output logic             f_rsp_valid,
    output logic [31:0]      f_rsp_data,
`ifdef IMEM_ALIGN_CHECK_EN
    output logic             f_rsp_err,
`endif
    input  logic             l_hold,
    output logic             l_hold_ack,
    input  logic             l_req_valid,
    output logic             l_req_ready,
    input  logic             l_we,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_rsp_valid,
    output logic [31:0]      l_rsp_data,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    state_e state_q;
    owner_e owner_q;
    logic   l_we_q;
    logic   hold_ack_q;
    logic   f_acc, l_acc, f_mis;
    logic   unused_addr;

    // Only the word-index bits select RAM words; the rest wrap or are ignored.
    assign unused_addr = ^{f_addr[31:IDX_W+2], f_addr[1:0], l_addr[31:IDX_W+2], l_addr[1:0]};

    imem_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (state_q == StRun),
        .load        (state_q == StLoad),
        .f_req_valid (f_req_valid),
        .l_req_valid (l_req_valid),
        .f_ready     (f_req_ready),
        .l_ready     (l_req_ready)
    );

    assign f_acc = f_req_valid && f_req_ready;
    assign l_acc = l_req_valid && l_req_ready;

`ifdef IMEM_ALIGN_CHECK_EN
    logic f_err_q;
    assign f_mis     = (f_addr[1:0] != 2'b00);
    assign f_rsp_err = f_err_q;
`else
    assign f_mis = 1'b0;
`endif

    // Drive the RAM with whichever request is accepted this cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_acc) begin
            // A misaligned fetch is answered with an error, never touching the RAM.
            if (!f_mis) begin
                mem_en   = 1'b1;
                mem_addr = f_addr[IDX_W+1:2];
            end
        end else if (l_acc) begin
            mem_en    = 1'b1;
            mem_we    = l_we;
            mem_addr  = l_addr[IDX_W+1:2];
            mem_wdata = l_we ? l_wdata : '0;
        end
    end

    // Route the one-cycle-late response to its owner only.
    always_comb begin
        f_rsp_valid = (owner_q == OwnFetch);
        f_rsp_data  = '0;
        l_rsp_valid = (owner_q == OwnLoader);
        l_rsp_data  = '0;
        if (owner_q == OwnFetch) begin
`ifdef IMEM_ALIGN_CHECK_EN
            f_rsp_data = f_err_q ? 32'h0 : mem_rdata;
`else
            f_rsp_data = mem_rdata;
`endif
        end
        if (owner_q == OwnLoader && !l_we_q) begin
            l_rsp_data = mem_rdata;
        end
    end

    assign l_hold_ack = hold_ack_q;

    // Mode FSM, response owner tag and registered hold acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            owner_q    <= OwnNone;
            l_we_q     <= 1'b0;
            hold_ack_q <= 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
            f_err_q    <= 1'b0;
`endif
        end else begin
            owner_q <= f_acc ? OwnFetch : (l_acc ? OwnLoader : OwnNone);
            l_we_q  <= l_acc && l_we;
`ifdef IMEM_ALIGN_CHECK_EN
            f_err_q <= f_acc && f_mis;
`endif
            unique case (state_q)
                StRun: begin
                    if (l_hold) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Nothing is accepted here, so any response in flight lands this
                    // cycle and ownership can pass at the next edge.
                    if (!l_hold) begin
                        state_q <= StRun;
                    end else begin
                        state_q    <= StLoad;
                        hold_ack_q <= 1'b1;
                    end
                end
                StLoad: begin
                    if (!l_hold) begin
                        state_q    <= StRun;
                        hold_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StRun;
                    hold_ack_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req_valid, f_req_ready;
    logic [31:0] f_addr;
    logic        f_rsp_valid;
    logic [31:0] f_rsp_data;
`ifdef IMEM_ALIGN_CHECK_EN
    logic        f_rsp_err;
`endif
    logic        l_hold, l_hold_ack;
    logic        l_req_valid, l_req_ready, l_we;
    logic [31:0] l_addr, l_wdata;
    logic        l_rsp_valid;
    logic [31:0] l_rsp_data;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] ram [256];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imem_arbiter #(
        .DEPTH        (256),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_req_valid (f_req_valid),
        .f_req_ready (f_req_ready),
        .f_addr      (f_addr),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
`ifdef IMEM_ALIGN_CHECK_EN
        .f_rsp_err   (f_rsp_err),
`endif
        .l_hold      (l_hold),
        .l_hold_ack  (l_hold_ack),
        .l_req_valid (l_req_valid),
        .l_req_ready (l_req_ready),
        .l_we        (l_we),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_rsp_valid (l_rsp_valid),
        .l_rsp_data  (l_rsp_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 2) ? 32'h0050_0093 : (32'hA000_0000 | 32'(i));
    endfunction

    // Behavioural RAM; preloaded while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_l;
        rst_n = 1'b0; f_req_valid = 1'b1; f_addr = 32'h8;
        l_hold = 1'b0; l_req_valid = 1'b1; l_we = 1'b1; l_addr = 32'h0; l_wdata = 32'h1;
        #2;
        chk("rst_f_ready", f_req_ready, 0);
        chk("rst_l_ready", l_req_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_f_rsp_valid", f_rsp_valid, 0);
        chk("rst_l_rsp_valid", l_rsp_valid, 0);
        chk("rst_hold_ack", l_hold_ack, 0);

        // Fetch-only read of word 2.
        l_req_valid = 1'b0; l_we = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        chk("fetch_ready", f_req_ready, 1);
        chk("fetch_mem_en", mem_en, 1);
        chk("fetch_mem_we", mem_we, 0);
        chk("fetch_mem_addr", mem_addr, 2);
        tick();
        chk("fetch_rsp_valid", f_rsp_valid, 1);
        chk("fetch_rsp_data", f_rsp_data, 32'h0050_0093);
        chk("fetch_no_l_rsp", l_rsp_valid, 0);

        // Asynchronous reset with a response pending.
        rst_n = 1'b0; #1;
        chk("midrst_f_rsp_valid", f_rsp_valid, 0);
        chk("midrst_f_rsp_data", f_rsp_data, 0);
        chk("midrst_f_ready", f_req_ready, 0);
        chk("midrst_mem_en", mem_en, 0);
        f_req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();
        chk("postrst_no_stale", f_rsp_valid, 0);

        // Upper address bits wrap onto the same word.
        f_req_valid = 1'b1; f_addr = 32'h408; #1;
        chk("wrap_mem_addr", mem_addr, 2);
        tick();
        chk("wrap_rsp_data", f_rsp_data, 32'h0050_0093);
        f_req_valid = 1'b0;
        tick();
        chk("rsp_single_pulse", f_rsp_valid, 0);

        // Contention: 4 fetch grants then 1 loader grant, repeating.
        f_req_valid = 1'b1; f_addr = 32'h0C; l_req_valid = 1'b1; l_we = 1'b0; l_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            exp_l = (i % 5 == 4);
            #1;
            chk($sformatf("cont%0d_f_ready", i), f_req_ready, !exp_l);
            chk($sformatf("cont%0d_l_ready", i), l_req_ready, exp_l);
            tick();
            chk($sformatf("cont%0d_f_rsp", i), f_rsp_valid, !exp_l);
            chk($sformatf("cont%0d_l_rsp", i), l_rsp_valid, exp_l);
            if (exp_l) chk($sformatf("cont%0d_l_data", i), l_rsp_data, 32'hA000_0008);
            else       chk($sformatf("cont%0d_f_data", i), f_rsp_data, 32'hA000_0003);
        end
        l_req_valid = 1'b0;
        f_addr = 32'h8;

        // Hold raised with a fetch being accepted.
        l_hold = 1'b1; #1;
        chk("hold_run_f_ready", f_req_ready, 1);
        tick();
        chk("drain_f_rsp", f_rsp_valid, 1);
        chk("drain_f_ready", f_req_ready, 0);
        chk("drain_l_ready", l_req_ready, 0);
        chk("drain_ack", l_hold_ack, 0);
        tick();
        chk("load_ack", l_hold_ack, 1);
        chk("load_f_ready", f_req_ready, 0);
        chk("load_l_ready", l_req_ready, 1);
        chk("load_no_f_rsp", f_rsp_valid, 0);

        l_req_valid = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'hDEAD_BEEF; #1;
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 4);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("wr_ack_valid", l_rsp_valid, 1);
        chk("wr_ack_data", l_rsp_data, 0);
        l_we = 1'b0; #1;
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 4);
        tick();
        chk("rd_valid", l_rsp_valid, 1);
        chk("rd_data", l_rsp_data, 32'hDEAD_BEEF);
        chk("rd_f_ready", f_req_ready, 0);

        // Release: ack drops at the edge and fetch resumes.
        l_req_valid = 1'b0; l_hold = 1'b0; f_addr = 32'h10; #1;
        chk("rel_ack_still", l_hold_ack, 1);
        tick();
        chk("rel_ack_low", l_hold_ack, 0);
        chk("rel_f_ready", f_req_ready, 1);
        tick();
        chk("rel_f_data", f_rsp_data, 32'hDEAD_BEEF);

        // One-cycle hold pulse: DRAIN then straight back to RUN.
        f_req_valid = 1'b0; l_hold = 1'b1;
        tick();
        l_hold = 1'b0; f_req_valid = 1'b1; f_addr = 32'h8; #1;
        chk("pulse_drain_f_ready", f_req_ready, 0);
        chk("pulse_drain_ack", l_hold_ack, 0);
        tick();
        chk("pulse_run_ack", l_hold_ack, 0);
        chk("pulse_run_f_ready", f_req_ready, 1);
        f_req_valid = 1'b0;
        tick();
        chk("pulse_ack_stays_low", l_hold_ack, 0);

        // Misaligned fetch.
        f_req_valid = 1'b1; f_addr = 32'h6; #1;
        chk("mis_f_ready", f_req_ready, 1);
`ifdef IMEM_ALIGN_CHECK_EN
        chk("mis_mem_en", mem_en, 0);
        tick();
        chk("mis_rsp_valid", f_rsp_valid, 1);
        chk("mis_rsp_err", f_rsp_err, 1);
        chk("mis_rsp_data", f_rsp_data, 0);
        f_addr = 32'h8;
        tick();
        chk("al_rsp_err", f_rsp_err, 0);
        chk("al_rsp_data", f_rsp_data, 32'h0050_0093);
`else
        chk("mis_mem_en", mem_en, 1);
        chk("mis_mem_addr", mem_addr, 1);
        tick();
        chk("mis_rsp_data", f_rsp_data, 32'hA000_0001);
`endif
        f_req_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
